// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if
//   Host request/response bus and SRAM wrapper pin bus of sram_access_ctrl.
//   Host side : iREQ/oREADY handshake, iWR, iADDR, iWDATA, iBE, oRDATA/oRVALID
//   SRAM side : oSRAM_DATA/iSRAM_DATA, oSRAM_ADDR, active-low strobes
//   SRAM_BURST_EN adds iBLEN (burst length - 1) and oWNEXT (next write word).
//   master = requester plus SRAM wrapper; slave = the controller.
interface sram_access_ctrl_if;
   logic        iREQ;
   logic        oREADY;
   logic        iWR;
   logic [17:0] iADDR;
   logic [15:0] iWDATA;
   logic [1:0]  iBE;
   logic [15:0] oRDATA;
   logic        oRVALID;
   logic [15:0] oSRAM_DATA;
   logic [15:0] iSRAM_DATA;
   logic [17:0] oSRAM_ADDR;
   logic        oSRAM_WE_N;
   logic        oSRAM_OE_N;
   logic        oSRAM_CE_N;
   logic        oSRAM_UB_N;
   logic        oSRAM_LB_N;
`ifdef SRAM_BURST_EN
   logic [3:0]  iBLEN;
   logic        oWNEXT;

   modport master (output iREQ, iWR, iADDR, iWDATA, iBE, iSRAM_DATA, iBLEN,
                   input  oREADY, oRDATA, oRVALID, oSRAM_DATA, oSRAM_ADDR,
                          oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N,
                          oSRAM_LB_N, oWNEXT);
   modport slave  (input  iREQ, iWR, iADDR, iWDATA, iBE, iSRAM_DATA, iBLEN,
                   output oREADY, oRDATA, oRVALID, oSRAM_DATA, oSRAM_ADDR,
                          oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N,
                          oSRAM_LB_N, oWNEXT);
`else
   modport master (output iREQ, iWR, iADDR, iWDATA, iBE, iSRAM_DATA,
                   input  oREADY, oRDATA, oRVALID, oSRAM_DATA, oSRAM_ADDR,
                          oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N,
                          oSRAM_LB_N);
   modport slave  (input  iREQ, iWR, iADDR, iWDATA, iBE, iSRAM_DATA,
                   output oREADY, oRDATA, oRVALID, oSRAM_DATA, oSRAM_ADDR,
                          oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N,
                          oSRAM_LB_N);
`endif
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Sequential access controller in front of the 16-bit x 256K SRAM pin
//   wrapper. Each beat is SETUP (1) + ACCESS (WAIT_CYCLES) + HOLD (1) cycles;
//   WE_N/OE_N only go low in ACCESS, so address/data never move under a
//   write strobe.
//   Ports:
//     iCLK  - system clock
//     iRST  - synchronous active-high reset
//     bus   - sram_access_ctrl_if.slave (host handshake + SRAM wrapper pins)
//   Parameter WAIT_CYCLES : ACCESS cycles per beat, 1..8.
//   Optional macro SRAM_BURST_EN : multi-beat bursts of iBLEN+1 words with
//   incrementing (wrapping) address and oWNEXT write-data requests.
module sram_access_ctrl #(
   parameter int WAIT_CYCLES = 1
) (
   input logic           iCLK,
   input logic           iRST,
   sram_access_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic        wr_q;
   logic [1:0]  be_q;
   logic [17:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic        last_acc;
   logic        last_beat;

`ifdef SRAM_BURST_EN
   logic [3:0]  beats_q;   // beats remaining after the current one
   assign last_beat = (beats_q == 4'd0);
`else
   assign last_beat = 1'b1;
`endif

   assign last_acc = (state == ACCESS) && (cnt == LAST_CNT);

   // next state and all strobes derive from the state register
   always_comb begin
      state_nxt      = state;
      bus.oREADY     = 1'b0;
      bus.oRVALID    = 1'b0;
      bus.oSRAM_CE_N = 1'b1;
      bus.oSRAM_WE_N = 1'b1;
      bus.oSRAM_OE_N = 1'b1;
      bus.oSRAM_UB_N = 1'b1;
      bus.oSRAM_LB_N = 1'b1;
`ifdef SRAM_BURST_EN
      bus.oWNEXT     = 1'b0;
`endif
      case (state)
         IDLE: begin
            bus.oREADY = 1'b1;
            if (bus.iREQ) state_nxt = SETUP;
         end
         SETUP: begin
            bus.oSRAM_CE_N = 1'b0;
            bus.oSRAM_UB_N = ~be_q[1];
            bus.oSRAM_LB_N = ~be_q[0];
            state_nxt      = ACCESS;
         end
         ACCESS: begin
            bus.oSRAM_CE_N = 1'b0;
            bus.oSRAM_UB_N = ~be_q[1];
            bus.oSRAM_LB_N = ~be_q[0];
            bus.oSRAM_WE_N = ~wr_q;
            bus.oSRAM_OE_N = wr_q;
            if (last_acc) state_nxt = HOLD;
         end
         HOLD: begin
            bus.oSRAM_CE_N = 1'b0;
            bus.oSRAM_UB_N = ~be_q[1];
            bus.oSRAM_LB_N = ~be_q[0];
            bus.oRVALID    = ~wr_q;
`ifdef SRAM_BURST_EN
            bus.oWNEXT     = wr_q & ~last_beat;
`endif
            state_nxt      = last_beat ? IDLE : SETUP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         wr_q    <= 1'b0;
         be_q    <= 2'b00;
         addr_q  <= 18'd0;
         wdata_q <= 16'd0;
         rdata_q <= 16'd0;
`ifdef SRAM_BURST_EN
         beats_q <= 4'd0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= (state == ACCESS) ? cnt + 3'd1 : 3'd0;

         if (state == IDLE && bus.iREQ) begin
            wr_q   <= bus.iWR;
            be_q   <= bus.iBE;
            addr_q <= bus.iADDR;
            // write data only moves for writes; otherwise the pins keep it
            if (bus.iWR) wdata_q <= bus.iWDATA;
`ifdef SRAM_BURST_EN
            beats_q <= bus.iBLEN;
`endif
         end

         if (last_acc && !wr_q) rdata_q <= bus.iSRAM_DATA;

`ifdef SRAM_BURST_EN
         // HOLD -> SETUP of the next beat: 18-bit add wraps naturally
         if (state == HOLD && !last_beat) begin
            addr_q  <= addr_q + 18'd1;
            beats_q <= beats_q - 4'd1;
            if (wr_q) wdata_q <= bus.iWDATA;
         end
`endif
      end
   end

   assign bus.oSRAM_ADDR = addr_q;
   assign bus.oSRAM_DATA = wdata_q;
   assign bus.oRDATA     = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl
//   Directed bench: dut1 (WAIT_CYCLES=1) talks to a small byte-lane SRAM
//   model; dut4 (WAIT_CYCLES=4) reads a constant bus value. Burst cases are
//   built only with SRAM_BURST_EN.
module tb_sram_access_ctrl;

   logic clk = 1'b0;
   logic rst1, rst4, clr_mem;
   always #5 clk = ~clk;

   sram_access_ctrl_if b1();
   sram_access_ctrl_if b4();

   sram_access_ctrl #(.WAIT_CYCLES(1)) dut1 (.iCLK(clk), .iRST(rst1), .bus(b1));
   sram_access_ctrl #(.WAIT_CYCLES(4)) dut4 (.iCLK(clk), .iRST(rst4), .bus(b4));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // SRAM model: word index from low address bits, byte lanes on UB_N/LB_N;
   // a write strobe seen on a reset edge never lands
   logic [15:0] mem [64];
   assign b1.iSRAM_DATA = (!b1.oSRAM_CE_N && !b1.oSRAM_OE_N) ? mem[b1.oSRAM_ADDR[5:0]] : 16'h0000;
   assign b4.iSRAM_DATA = 16'hBEEF;

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      end else if (!rst1 && !b1.oSRAM_CE_N && !b1.oSRAM_WE_N) begin
         if (!b1.oSRAM_UB_N) mem[b1.oSRAM_ADDR[5:0]][15:8] <= b1.oSRAM_DATA[15:8];
         if (!b1.oSRAM_LB_N) mem[b1.oSRAM_ADDR[5:0]][7:0]  <= b1.oSRAM_DATA[7:0];
      end
   end

   // address/data must not move across any edge touching a WE_N-low cycle
   logic        rst_edge = 1'b0;
   logic        prev_we = 1'b1;
   logic [17:0] prev_addr = '0;
   logic [15:0] prev_data = '0;
   int          we_viol = 0;
   always @(posedge clk) rst_edge <= rst1;
   always @(negedge clk) begin
      if (!rst_edge && (!b1.oSRAM_WE_N || !prev_we) &&
          (b1.oSRAM_ADDR !== prev_addr || b1.oSRAM_DATA !== prev_data))
         we_viol <= we_viol + 1;
      prev_we   <= b1.oSRAM_WE_N;
      prev_addr <= b1.oSRAM_ADDR;
      prev_data <= b1.oSRAM_DATA;
   end

   // per-transaction observations on dut1, cycle 0 = accept cycle
   int          we_lo, oe_lo, we_first, rv_n, rdy_back, wnext_n;
   int          rv_cyc [$];
   logic [15:0] rv_dat [$];
   logic [17:0] rv_adr [$];
   logic        ub_acc, lb_acc, post_we, post_ce, post_rdy;

   task automatic run1(input bit wr, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic [3:0] blen,
                       input bit rst_mid, input bit poke);
      int guard = 0;
      @(negedge clk);
      while (!b1.oREADY && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
      b1.iREQ = 1'b1; b1.iWR = wr; b1.iADDR = a; b1.iWDATA = d; b1.iBE = be;
`ifdef SRAM_BURST_EN
      b1.iBLEN = blen;
`endif
      we_lo = 0; oe_lo = 0; we_first = -1; rv_n = 0; rdy_back = -1; wnext_n = 0;
      rv_cyc.delete(); rv_dat.delete(); rv_adr.delete();
      ub_acc = 1'b1; lb_acc = 1'b1;
      for (int k = 1; k <= 4 * (int'(blen) + 1) + 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            b1.iREQ = poke;
            if (poke) begin
               b1.iWR = 1'b1; b1.iADDR = 18'h10; b1.iWDATA = 16'hDEAD; b1.iBE = 2'b11;
            end
         end
         if (k == 3) b1.iREQ = 1'b0;
         if (rst_mid && k == 3) begin
            post_we = b1.oSRAM_WE_N; post_ce = b1.oSRAM_CE_N; post_rdy = b1.oREADY;
            rst1 = 1'b0;
         end
         if (!b1.oSRAM_WE_N) begin
            we_lo++;
            if (we_first < 0) we_first = k;
         end
         if (!b1.oSRAM_OE_N) oe_lo++;
         if (!b1.oSRAM_WE_N || !b1.oSRAM_OE_N) begin
            ub_acc = b1.oSRAM_UB_N; lb_acc = b1.oSRAM_LB_N;
         end
         if (b1.oRVALID) begin
            rv_n++;
            rv_cyc.push_back(k); rv_dat.push_back(b1.oRDATA); rv_adr.push_back(b1.oSRAM_ADDR);
         end
`ifdef SRAM_BURST_EN
         if (b1.oWNEXT) begin
            wnext_n++;
            b1.iWDATA = d + 16'(wnext_n);
         end
`endif
         if (b1.oREADY && rdy_back < 0) rdy_back = k;
         if (rst_mid && k == 2) rst1 = 1'b1;
      end
   endtask

   task automatic rd1(input string tag, input logic [17:0] a, input logic [15:0] exp);
      run1(1'b0, a, 16'h0, 2'b11, 4'd0, 1'b0, 1'b0);
      chk({tag, "_rvn"}, rv_n, 1);
      if (rv_n > 0) chk({tag, "_data"}, rv_dat[0], exp);
   endtask

   initial begin
      int oe4, rv4_cyc, rdy4, rv4_n;
      logic [15:0] rd4;
      rst1 = 1'b1; rst4 = 1'b1; clr_mem = 1'b1;
      b1.iREQ = 0; b1.iWR = 0; b1.iADDR = 0; b1.iWDATA = 0; b1.iBE = 0;
      b4.iREQ = 0; b4.iWR = 0; b4.iADDR = 0; b4.iWDATA = 0; b4.iBE = 0;
`ifdef SRAM_BURST_EN
      b1.iBLEN = 0; b4.iBLEN = 0;
`endif
      repeat (3) @(negedge clk);
      rst1 = 1'b0; rst4 = 1'b0; clr_mem = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_ready", b1.oREADY, 1);
      chk("rst_rvalid", b1.oRVALID, 0);
      chk("rst_strobes", {b1.oSRAM_WE_N, b1.oSRAM_OE_N, b1.oSRAM_CE_N, b1.oSRAM_UB_N, b1.oSRAM_LB_N}, 5'b11111);
      chk("rst_addr", b1.oSRAM_ADDR, 0);
      chk("rst_wdata", b1.oSRAM_DATA, 0);
      chk("rst_rdata", b1.oRDATA, 0);
      chk("rst4_ready", b4.oREADY, 1);
`ifdef SRAM_BURST_EN
      chk("rst_wnext", b1.oWNEXT, 0);
`endif

      // single write then read, WAIT_CYCLES=1
      run1(1'b1, 18'h00010, 16'hA5C3, 2'b11, 4'd0, 1'b0, 1'b0);
      chk("wr_we_width", we_lo, 1);
      chk("wr_we_cycle", we_first, 2);
      chk("wr_no_rvalid", rv_n, 0);
      chk("wr_ready_back", rdy_back, 4);
      run1(1'b0, 18'h00010, 16'h0, 2'b11, 4'd0, 1'b0, 1'b0);
      chk("rd_oe_width", oe_lo, 1);
      chk("rd_rvn", rv_n, 1);
      if (rv_n > 0) begin
         chk("rd_rv_cycle", rv_cyc[0], 3);
         chk("rd_data", rv_dat[0], 16'hA5C3);
      end
      chk("rd_ready_back", rdy_back, 4);

      // upper byte only over 0xFFFF
      run1(1'b1, 18'h00030, 16'hFFFF, 2'b11, 4'd0, 1'b0, 1'b0);
      run1(1'b1, 18'h00030, 16'h1234, 2'b10, 4'd0, 1'b0, 1'b0);
      chk("be10_ublb", {ub_acc, lb_acc}, 2'b01);
      rd1("be10_rd", 18'h00030, 16'h12FF);

      // no byte enables: full cycle, nothing written
      run1(1'b1, 18'h00010, 16'h0000, 2'b00, 4'd0, 1'b0, 1'b0);
      chk("be00_we_width", we_lo, 1);
      chk("be00_ublb", {ub_acc, lb_acc}, 2'b11);
      rd1("be00_rd", 18'h00010, 16'hA5C3);

      // reset during ACCESS of a write
      run1(1'b1, 18'h00020, 16'h0F0F, 2'b11, 4'd0, 1'b0, 1'b0);
      run1(1'b1, 18'h00020, 16'h5555, 2'b11, 4'd0, 1'b1, 1'b0);
      chk("rstmid_we", post_we, 1);
      chk("rstmid_ce", post_ce, 1);
      chk("rstmid_ready", post_rdy, 1);
      chk("rstmid_rvalid", rv_n, 0);
      rd1("rstmid_rd", 18'h00020, 16'h0F0F);

      // request while busy is dropped
      run1(1'b0, 18'h00030, 16'h0, 2'b11, 4'd0, 1'b0, 1'b1);
      chk("busy_rvn", rv_n, 1);
      rd1("busy_rd", 18'h00010, 16'hA5C3);

      // pulse width, WAIT_CYCLES=4
      oe4 = 0; rv4_cyc = -1; rdy4 = -1; rv4_n = 0; rd4 = 16'h0;
      @(negedge clk);
      b4.iREQ = 1'b1; b4.iWR = 1'b0; b4.iADDR = 18'h00005; b4.iBE = 2'b11;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) b4.iREQ = 1'b0;
         if (!b4.oSRAM_OE_N) oe4++;
         if (b4.oRVALID) begin
            rv4_n++;
            if (rv4_cyc < 0) begin rv4_cyc = k; rd4 = b4.oRDATA; end
         end
         if (b4.oREADY && rdy4 < 0) rdy4 = k;
      end
      chk("w4_oe_width", oe4, 4);
      chk("w4_rv_cycle", rv4_cyc, 6);
      chk("w4_rvn", rv4_n, 1);
      chk("w4_data", rd4, 16'hBEEF);
      chk("w4_ready_back", rdy4, 7);

`ifdef SRAM_BURST_EN
      // burst read across the top of the address space
      run1(1'b0, 18'h3FFFE, 16'h0, 2'b11, 4'd3, 1'b0, 1'b0);
      chk("brd_rvn", rv_n, 4);
      if (rv_n == 4) begin
         chk("brd_a0", rv_adr[0], 18'h3FFFE);
         chk("brd_a1", rv_adr[1], 18'h3FFFF);
         chk("brd_a2", rv_adr[2], 18'h00000);
         chk("brd_a3", rv_adr[3], 18'h00001);
         chk("brd_c0", rv_cyc[0], 3);
         for (int i = 1; i < 4; i++) chk("brd_gap", rv_cyc[i] - rv_cyc[i-1], 3);
      end
      chk("brd_ready_back", rdy_back, 13);

      // burst write 1/2/3 advanced on oWNEXT
      run1(1'b1, 18'h00040, 16'h0001, 2'b11, 4'd2, 1'b0, 1'b0);
      chk("bwr_wnext", wnext_n, 2);
      chk("bwr_no_rvalid", rv_n, 0);
      chk("bwr_we_width", we_lo, 3);
      rd1("bwr_rd0", 18'h00040, 16'h0001);
      rd1("bwr_rd1", 18'h00041, 16'h0002);
      rd1("bwr_rd2", 18'h00042, 16'h0003);
`endif

      chk("we_stable", we_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
